// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between EXU and the data memory port.
//
// Accepts one memory operation per EXU handshake, checks alignment and memop
// legality, drives an aligned word request with byte mask and lane-replicated
// store data, waits a variable number of cycles for mem_ack (bounded by
// MAX_WAIT), then extracts/extends load data and presents the result to WBU.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   EXU handshake
//   in_ren, in_wen      load / store (both set = load, neither = no-op)
//   in_memop            000 b, 001 h, 010 w, 100 bu, 101 hu
//   in_addr, in_wdata   byte address and store data
//   in_rd               destination tag, passed through to out_rd
//   out_valid/out_ready WBU handshake
//   out_rdata, out_rd   extended load data and tag
//   out_err             00 ok, 01 misaligned/illegal, 10 timeout
//   mem_req..mem_wmask  memory request, held until mem_ack
//   mem_ack, mem_rdata  one-cycle completion pulse with aligned read word
module lsu_ctrl #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_memop,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic [1:0]  out_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [2:0]  op_q;
    logic [1:0]  off_q;

    // Acceptance-time decode
    logic        is_load, is_noop, bad_op, misal;
    logic [31:0] st_data;
    logic [3:0]  st_mask;

    always_comb begin
        is_noop = ~in_ren & ~in_wen;
        is_load = in_ren;  // ren+wen together is a load
        // 011/110/111 are undefined; bu/hu only make sense on loads
        bad_op  = (in_memop == 3'b011) || (in_memop[2] && in_memop[1]) ||
                  (!is_load && in_memop[2]);
        misal   = (in_memop[1:0] == 2'b01 && in_addr[0]) ||
                  (in_memop[1:0] == 2'b10 && in_addr[1:0] != 2'b00);
        case (in_memop[1:0])
            2'b00: begin
                st_data = {4{in_wdata[7:0]}};
                st_mask = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                st_data = {2{in_wdata[15:0]}};
                st_mask = 4'b0011 << in_addr[1:0];
            end
            default: begin
                st_data = in_wdata;
                st_mask = 4'b1111;
            end
        endcase
    end

    // Load extraction from the latched memop and byte offset
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_val;

    always_comb begin
        case (off_q)
            2'd0:    ld_b = mem_rdata[7:0];
            2'd1:    ld_b = mem_rdata[15:8];
            2'd2:    ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase
        ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
            3'b100:  ld_val = {24'h0, ld_b};
            3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
            3'b101:  ld_val = {16'h0, ld_h};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_q      <= '0;
            off_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_rdata <= '0;
            out_rd    <= '0;
            out_err   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        op_q     <= in_memop;
                        off_q    <= in_addr[1:0];
                        out_rd   <= in_rd;
                        wait_cnt <= '0;
                        if (is_noop || bad_op || misal) begin
                            // No memory access; result is ready next cycle
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_rdata <= '0;
                            out_err   <= is_noop ? 2'b00 : 2'b01;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ~is_load;
                            mem_addr  <= in_addr & 32'hFFFF_FFFC;
                            mem_wdata <= is_load ? 32'h0 : st_data;
                            mem_wmask <= is_load ? 4'h0 : st_mask;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the last allowed
                    // cycle still completes successfully.
                    if (mem_ack) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        out_valid <= 1'b1;
                        out_err   <= 2'b00;
                        out_rdata <= mem_we ? 32'h0 : ld_val;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        out_valid <= 1'b1;
                        out_err   <= 2'b10;
                        out_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_rdata <= '0;
                        out_rd    <= '0;
                        out_err   <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [2:0]  in_memop;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic [1:0]  out_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_memop(in_memop), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_rd(out_rd), .out_err(out_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   req_cycles = 0;

    always @(posedge clk) if (mem_req === 1'b1) req_cycles++;

    // Drive one operation; the expected result goes to the scoreboard now.
    task automatic issue(input logic ren, input logic wen, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_err);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_memop = op;
        in_addr = addr; in_wdata = wdata; in_rd = rd;
        e.rdata = exp_rdata; e.rd = rd; e.err = exp_err;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    // Memory side: check the request, ack after lat cycles of mem_req.
    task automatic mem_resp(input int lat, input logic [31:0] rdata, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mask);
        tests++;
        if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== addr ||
            mem_wdata !== wdata || mem_wmask !== mask || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mem_request: req=%b we=%b addr=%h wdata=%h mask=%b ov=%b, need req=1 we=%b addr=%h wdata=%h mask=%b ov=0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid, we, addr, wdata, mask);
        end
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== addr ||
            mem_wdata !== wdata || mem_wmask !== mask || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mem_stable: req=%b we=%b addr=%h wdata=%h mask=%b ov=%b",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, out_valid);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL ack_latency: req=%b ov=%b, need req=0 ov=1", mem_req, out_valid);
        end
    endtask

    // Wait for a result, compare with the scoreboard head, optionally stall.
    task automatic get_result(input int hold);
        int   n = 0;
        exp_t e;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (out_valid !== 1'b1 || sb_q.size() == 0) begin
            fails++;
            $display("FAIL result_wait: out_valid=%b queued=%0d", out_valid, sb_q.size());
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        tests++;
        if (out_rdata !== e.rdata || out_rd !== e.rd || out_err !== e.err || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL result: rdata=%h rd=%0d err=%b in_ready=%b, need rdata=%h rd=%0d err=%b in_ready=0",
                     out_rdata, out_rd, out_err, in_ready, e.rdata, e.rd, e.err);
        end
        repeat (hold) begin
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_rdata !== e.rdata || out_rd !== e.rd ||
                out_err !== e.err || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL result_hold: ov=%b rdata=%h rd=%0d err=%b in_ready=%b",
                         out_valid, out_rdata, out_rd, out_err, in_ready);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release: ov=%b in_ready=%b, need ov=0 in_ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_rdata !== 32'h0 || out_rd !== 5'd0 ||
            out_err !== 2'b00 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b ov=%b rdata=%h rd=%0d err=%b req=%b we=%b addr=%h wdata=%h mask=%b",
                     in_ready, out_valid, out_rdata, out_rd, out_err, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_loads();
        issue(1, 0, 3'b000, 32'h8000_0003, 32'h0, 5'd7, 32'hFFFF_FF80, 2'b00);    // lb
        mem_resp(2, 32'h80FF_1234, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        get_result(0);
        issue(1, 0, 3'b101, 32'h8000_0002, 32'h0, 5'd9, 32'h0000_BEEF, 2'b00);    // lhu
        mem_resp(1, 32'hBEEF_0000, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        get_result(0);
        issue(1, 0, 3'b001, 32'h8000_0002, 32'h0, 5'd10, 32'hFFFF_BEEF, 2'b00);   // lh
        mem_resp(3, 32'hBEEF_0000, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        get_result(0);
        issue(1, 0, 3'b100, 32'h8000_0001, 32'h0, 5'd11, 32'h0000_00A5, 2'b00);   // lbu
        mem_resp(1, 32'h0000_A500, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        get_result(0);
        issue(1, 1, 3'b010, 32'h8000_0008, 32'h5555_5555, 5'd12, 32'h1234_5678, 2'b00); // ren+wen = lw
        mem_resp(2, 32'h1234_5678, 1'b0, 32'h8000_0008, 32'h0, 4'h0);
        get_result(0);
    endtask

    task automatic test_stores();
        issue(0, 1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 5'd3, 32'h0, 2'b00);    // sb
        mem_resp(2, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'hABAB_ABAB, 4'b0010);
        get_result(0);
        issue(0, 1, 3'b001, 32'h8000_0002, 32'h0000_CAFE, 5'd4, 32'h0, 2'b00);    // sh
        mem_resp(1, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'hCAFE_CAFE, 4'b1100);
        get_result(0);
        issue(0, 1, 3'b010, 32'h8000_0004, 32'h1122_3344, 5'd5, 32'h0, 2'b00);    // sw
        mem_resp(1, 32'hFFFF_FFFF, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'b1111);
        get_result(0);
    endtask

    task automatic test_errors();
        int base = req_cycles;
        issue(1, 0, 3'b010, 32'h8000_0002, 32'h0, 5'd1, 32'h0, 2'b01);            // misaligned lw
        tests++;
        if (out_valid !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL err_latency: ov=%b req=%b, need ov=1 req=0", out_valid, mem_req);
        end
        get_result(0);
        issue(0, 1, 3'b001, 32'h8000_0001, 32'h0, 5'd2, 32'h0, 2'b01);            // misaligned sh
        get_result(0);
        issue(0, 1, 3'b100, 32'h8000_0000, 32'h0, 5'd6, 32'h0, 2'b01);            // sbu is illegal
        get_result(0);
        issue(1, 0, 3'b111, 32'h8000_0000, 32'h0, 5'd8, 32'h0, 2'b01);            // undefined memop
        get_result(0);
        issue(0, 0, 3'b010, 32'h8000_0001, 32'h0, 5'd13, 32'h0, 2'b00);           // no-op
        tests++;
        if (out_valid !== 1'b1 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL noop_latency: ov=%b req=%b, need ov=1 req=0", out_valid, mem_req);
        end
        get_result(0);
        tests++;
        if (req_cycles !== base) begin
            fails++;
            $display("FAIL no_mem_access: mem_req cycles=%0d, need 0", req_cycles - base);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1, 0, 3'b010, 32'h8000_0010, 32'h0, 5'd20, 32'h0, 2'b10);
        while (mem_req === 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        tests++;
        if (n !== MW || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL timeout_len: mem_req cycles=%0d ov=%b, need %0d and ov=1", n, out_valid, MW);
        end
        get_result(3);
    endtask

    task automatic test_reset_mid();
        issue(1, 0, 3'b010, 32'h8000_0020, 32'h0, 5'd21, 32'h0, 2'b00);
        sb_q.delete();  // this operation is abandoned by the reset
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: req=%b ov=%b in_ready=%b, need 0 0 1", mem_req, out_valid, in_ready);
        end
        @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_DEAD;
        @(posedge clk); #1; mem_ack = 1'b0; mem_rdata = 32'h0;
        tests++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stray_ack: req=%b ov=%b in_ready=%b, need 0 0 1", mem_req, out_valid, in_ready);
        end
        issue(1, 0, 3'b010, 32'h8000_0024, 32'h0, 5'd22, 32'hCAFE_F00D, 2'b00);
        mem_resp(2, 32'hCAFE_F00D, 1'b0, 32'h8000_0024, 32'h0, 4'h0);
        get_result(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_valid = 0; in_ren = 0; in_wen = 0; in_memop = 0; in_addr = 0; in_wdata = 0; in_rd = 0;
        out_ready = 0; mem_ack = 0; mem_rdata = 0; rst_n = 0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
